load_use_scoreboard: RTL

- Parametrised successor to the single-cycle load-use hazard detector. Sits between decode and execute.
- Keeps a per-register countdown of cycles until a pending load result can be forwarded.
- Stalls fetch/decode while any source operand the decoding instruction actually uses is still pending.
- Supports multi-cycle memory latency, N source operands, operand-use masking (so MOV-type instructions that ignore a field do not stall), and pipeline flush.

---
 rtl/load_use_scoreboard.sv | 120 ++++++++++++
 1 files changed

// File: rtl/load_use_scoreboard.sv
// Load-use scoreboard: per-register countdown of cycles until a pending load
// result becomes forwardable; stalls fetch/decode while a used source operand
// is still pending. Optional stall statistics are compiled in with the macro
// HDU_STALL_STATS_EN (adds stall_cycles / stall_events outputs).

// One register's countdown: restarts on a load, drains to zero, flush clears.
module lus_reg_cnt #(
  parameter int CW       = 1,
  parameter int LOAD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          load_set,
  output logic [CW-1:0] cnt_q
);
  localparam logic [CW-1:0] LAT_V = CW'(LOAD_LAT);
  logic [CW-1:0] cnt_d;

  // Flush wins, then a new load restarts the count, otherwise drain to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (flush)               cnt_d = '0;
    else if (load_set)       cnt_d = LAT_V;
    else if (cnt_q != '0)    cnt_d = cnt_q - CW'(1);
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

module load_use_scoreboard #(
  parameter int REG_AW   = 3,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1,
  localparam int NUM_REGS = 2**REG_AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dec_valid,
  input  logic [NSRC*REG_AW-1:0] dec_src_addr,
  input  logic [NSRC-1:0]        dec_src_used,
  input  logic [REG_AW-1:0]      dec_dest,
  input  logic                   dec_is_load,
  input  logic                   flush,
  output logic                   stall_fetch,
  output logic                   stall_decode,
  output logic [NUM_REGS-1:0]    busy_vec
`ifdef HDU_STALL_STATS_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [15:0]            stall_events
`endif
);
  localparam int CW = $clog2(LOAD_LAT + 2);

  logic [NUM_REGS-1:0][CW-1:0] cnt;
  logic [NUM_REGS-1:0]         load_set;
  logic                        src_hit, hazard, accept;

  // A source only matters when the instruction really reads that field.
  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (dec_src_used[i] && busy_vec[dec_src_addr[i*REG_AW +: REG_AW]])
        src_hit = 1'b1;
  end

  assign hazard       = dec_valid && !flush && src_hit;
  assign accept       = dec_valid && !flush && !hazard;
  assign stall_fetch  = hazard;
  assign stall_decode = hazard;

  genvar r;
  generate
    for (r = 0; r < NUM_REGS; r++) begin : g_reg
      assign load_set[r] = accept && dec_is_load && (dec_dest == REG_AW'(r));
      assign busy_vec[r] = (cnt[r] != '0);
      lus_reg_cnt #(.CW(CW), .LOAD_LAT(LOAD_LAT)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .load_set (load_set[r]),
        .cnt_q    (cnt[r])
      );
    end
  endgenerate

`ifdef HDU_STALL_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] stall_events_q, stall_events_d;
  logic        hazard_prev_q,  hazard_prev_d;

  // Count stalled cycles and stall episodes (rising edges of hazard); flush does not clear.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    stall_events_d = stall_events_q;
    hazard_prev_d  = hazard;
    if (hazard)                   stall_cycles_d = stall_cycles_q + 32'd1;
    if (hazard && !hazard_prev_q) stall_events_d = stall_events_q + 16'd1;
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cycles_q <= '0;
      stall_events_q <= '0;
      hazard_prev_q  <= 1'b0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      stall_events_q <= stall_events_d;
      hazard_prev_q  <= hazard_prev_d;
    end

  assign stall_cycles = stall_cycles_q;
  assign stall_events = stall_events_q;
`endif
endmodule
